// File: rtl/fp_dot_product_seq.sv
// rtl/fp_dot_product_seq.sv - sequencer driving a shared FPU bus to compute sum(x[i]*w[i])
// Optional BIAS_INIT_EN adds a bias input that seeds the accumulator.
module fp_dot_product_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_W      = 8,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [LEN_W-1:0]      len,
`ifdef BIAS_INIT_EN
  input  logic [DATA_WIDTH-1:0] bias,
`endif
  input  logic                  elem_valid,
  input  logic [DATA_WIDTH-1:0] elem_x,
  input  logic [DATA_WIDTH-1:0] elem_w,
  output logic                  elem_ready,
  output logic [DATA_WIDTH-1:0] fpu_a,
  output logic [DATA_WIDTH-1:0] fpu_b,
  output logic                  mul_start,
  output logic                  add_start,
  input  logic [DATA_WIDTH-1:0] mult_out,
  input  logic [DATA_WIDTH-1:0] add_out,
  input  logic                  mult_done,
  input  logic                  add_done,
  output logic                  busy,
  output logic                  res_valid,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic                  err_timeout
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOAD      = 3'd1;
  localparam logic [2:0] S_WAIT_ELEM = 3'd2;
  localparam logic [2:0] S_MUL_ISSUE = 3'd3;
  localparam logic [2:0] S_MUL_WAIT  = 3'd4;
  localparam logic [2:0] S_ADD_ISSUE = 3'd5;
  localparam logic [2:0] S_ADD_WAIT  = 3'd6;
  localparam logic [2:0] S_DONE      = 3'd7;

  localparam int WCW = $clog2(TIMEOUT + 1);
  // Wait counter starts at 0 on the first wait cycle, so TIMEOUT-1 marks the last one.
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);

  logic [2:0]            state_q, state_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [LEN_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] x_q, x_d;
  logic [DATA_WIDTH-1:0] w_q, w_d;
  logic [DATA_WIDTH-1:0] prod_q, prod_d;
  logic [WCW-1:0]        wait_q, wait_d;
  logic [DATA_WIDTH-1:0] res_data_q, res_data_d;
  logic [DATA_WIDTH-1:0] acc_init;
  logic [LEN_W-1:0]      count_inc;

`ifdef BIAS_INIT_EN
  assign acc_init = bias;
`else
  assign acc_init = '0;
`endif

  assign count_inc = count_q + LEN_W'(1);

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    count_d     = count_q;
    acc_d       = acc_q;
    x_d         = x_q;
    w_d         = w_q;
    prod_d      = prod_q;
    wait_d      = wait_q;
    res_data_d  = res_data_q;
    err_timeout = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d   = len;
          acc_d   = acc_init;
          count_d = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (len_q == '0) begin
          res_data_d = acc_q;
          state_d    = S_DONE;
        end else begin
          state_d = S_WAIT_ELEM;
        end
      end
      S_WAIT_ELEM: begin
        if (elem_valid) begin
          x_d     = elem_x;
          w_d     = elem_w;
          state_d = S_MUL_ISSUE;
        end
      end
      S_MUL_ISSUE: begin
        wait_d  = '0;
        state_d = S_MUL_WAIT;
      end
      S_MUL_WAIT: begin
        if (mult_done) begin
          prod_d  = mult_out;
          state_d = S_ADD_ISSUE;
        end else if (wait_q == WAIT_LAST) begin
          err_timeout = 1'b1;
          state_d     = S_IDLE;
        end else begin
          wait_d = wait_q + WCW'(1);
        end
      end
      S_ADD_ISSUE: begin
        wait_d  = '0;
        state_d = S_ADD_WAIT;
      end
      S_ADD_WAIT: begin
        if (add_done) begin
          acc_d   = add_out;
          count_d = count_inc;
          if (count_inc == len_q) begin
            res_data_d = add_out;
            state_d    = S_DONE;
          end else begin
            state_d = S_WAIT_ELEM;
          end
        end else if (wait_q == WAIT_LAST) begin
          err_timeout = 1'b1;
          state_d     = S_IDLE;
        end else begin
          wait_d = wait_q + WCW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      count_q    <= '0;
      acc_q      <= '0;
      x_q        <= '0;
      w_q        <= '0;
      prod_q     <= '0;
      wait_q     <= '0;
      res_data_q <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      count_q    <= count_d;
      acc_q      <= acc_d;
      x_q        <= x_d;
      w_q        <= w_d;
      prod_q     <= prod_d;
      wait_q     <= wait_d;
      res_data_q <= res_data_d;
    end
  end

  // Operands are pure functions of state, so they stay put from issue until done.
  logic mul_phase, add_phase;
  assign mul_phase = (state_q == S_MUL_ISSUE) || (state_q == S_MUL_WAIT);
  assign add_phase = (state_q == S_ADD_ISSUE) || (state_q == S_ADD_WAIT);

  assign fpu_a      = mul_phase ? x_q : (add_phase ? acc_q  : '0);
  assign fpu_b      = mul_phase ? w_q : (add_phase ? prod_q : '0);
  assign mul_start  = (state_q == S_MUL_ISSUE);
  assign add_start  = (state_q == S_ADD_ISSUE);
  assign elem_ready = (state_q == S_WAIT_ELEM);
  assign busy       = (state_q != S_IDLE);
  assign res_valid  = (state_q == S_DONE);
  assign res_data   = res_data_q;

endmodule

// File: tb/tb_fp_dot_product_seq.sv
// tb/tb_fp_dot_product_seq.sv - directed bench for fp_dot_product_seq with a table-driven FPU model
module tb_fp_dot_product_seq;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [7:0]  len;
`ifdef BIAS_INIT_EN
  logic [31:0] bias;
`endif
  logic        elem_valid;
  logic [31:0] elem_x, elem_w;
  logic        elem_ready;
  logic [31:0] fpu_a, fpu_b;
  logic        mul_start, add_start;
  logic [31:0] mult_out, add_out;
  logic        mult_done, add_done;
  logic        busy, res_valid, err_timeout;
  logic [31:0] res_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp_dot_product_seq #(.DATA_WIDTH(32), .LEN_W(8), .TIMEOUT(64)) dut (
    .clk(clk), .rstn(rstn), .start(start), .len(len),
`ifdef BIAS_INIT_EN
    .bias(bias),
`endif
    .elem_valid(elem_valid), .elem_x(elem_x), .elem_w(elem_w), .elem_ready(elem_ready),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .mul_start(mul_start), .add_start(add_start),
    .mult_out(mult_out), .add_out(add_out), .mult_done(mult_done), .add_done(add_done),
    .busy(busy), .res_valid(res_valid), .res_data(res_data), .err_timeout(err_timeout)
  );

  // Hand-computed IEEE-754 results for the operand pairs used below.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h3F800000, 32'h3F800000}: fmul = 32'h3F800000;
      {32'h40000000, 32'h40000000}: fmul = 32'h40800000;
      {32'h40400000, 32'h40400000}: fmul = 32'h41100000;
      {32'h40000000, 32'h40800000}: fmul = 32'h41000000;
      default:                      fmul = 32'hDEADBEEF;
    endcase
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h00000000, 32'h3F800000}: fadd = 32'h3F800000;
      {32'h3F800000, 32'h40800000}: fadd = 32'h40A00000;
      {32'h40A00000, 32'h41100000}: fadd = 32'h41600000;
      {32'h00000000, 32'h41100000}: fadd = 32'h41100000;
      {32'h00000000, 32'h41000000}: fadd = 32'h41000000;
      {32'h3F000000, 32'h41000000}: fadd = 32'h41080000;
      default:                      fadd = 32'hDEADBEEF;
    endcase
  endfunction

  logic [1:0]  mcnt, acnt;
  logic [31:0] mres, ares;
  logic        mult_hang;
  int          n_mul = 0, n_add = 0, n_res = 0, n_err = 0;

  always @(posedge clk) begin
    if (!rstn) begin
      mcnt <= 2'd0;
      acnt <= 2'd0;
      mres <= 32'd0;
      ares <= 32'd0;
    end else begin
      if (mul_start) begin
        mcnt <= 2'd3;
        mres <= fmul(fpu_a, fpu_b);
      end else if (mcnt != 2'd0) mcnt <= mcnt - 2'd1;
      if (add_start) begin
        acnt <= 2'd3;
        ares <= fadd(fpu_a, fpu_b);
      end else if (acnt != 2'd0) acnt <= acnt - 2'd1;
    end
    if (mul_start)   n_mul++;
    if (add_start)   n_add++;
    if (res_valid)   n_res++;
    if (err_timeout) n_err++;
  end

  assign mult_done = (mcnt == 2'd1) && !mult_hang;
  assign add_done  = (acnt == 2'd1);
  assign mult_out  = mres;
  assign add_out   = ares;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_start(input logic [7:0] n);
    start = 1'b1;
    len   = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic feed(input logic [31:0] x, input logic [31:0] w);
    bit ok = 1'b0;
    for (int t = 0; t < 300; t++) begin
      if (elem_ready) begin
        elem_valid = 1'b1;
        elem_x     = x;
        elem_w     = w;
        @(negedge clk);
        elem_valid = 1'b0;
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("feed_handshake", 32'(ok), 32'd1);
  endtask

  task automatic wait_res(input string tag, input logic [31:0] exp);
    bit ok = 1'b0;
    for (int t = 0; t < 300; t++) begin
      if (res_valid) begin
        ok = 1'b1;
        check(tag, res_data, exp);
        break;
      end
      @(negedge clk);
    end
    check({tag, "_seen"}, 32'(ok), 32'd1);
    @(negedge clk);
  endtask

  int b_mul, b_add, b_res, b_err, kk;

  initial begin
    rstn = 1'b0; start = 1'b0; len = 8'd0; elem_valid = 1'b0;
    elem_x = 32'd0; elem_w = 32'd0; mult_hang = 1'b0;
`ifdef BIAS_INIT_EN
    bias = 32'd0;
`endif
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_data", res_data, 32'd0);
    check("rst_elem_ready", 32'(elem_ready), 32'd0);
    check("rst_fpu_a", fpu_a, 32'd0);
    check("rst_starts", {30'd0, mul_start, add_start}, 32'd0);
    check("rst_err", 32'(err_timeout), 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    // 1.0^2 + 2.0^2 + 3.0^2 = 14.0
    b_mul = n_mul; b_add = n_add; b_res = n_res;
    do_start(8'd3);
    feed(32'h3F800000, 32'h3F800000);
    feed(32'h40000000, 32'h40000000);
    feed(32'h40400000, 32'h40400000);
    wait_res("s1_result", 32'h41600000);
    repeat (3) @(negedge clk);
    check("s1_mul_pulses", 32'(n_mul - b_mul), 32'd3);
    check("s1_add_pulses", 32'(n_add - b_add), 32'd3);
    check("s1_res_pulses", 32'(n_res - b_res), 32'd1);
    check("s1_busy_after", 32'(busy), 32'd0);

    // Empty vector: result two cycles after start, no FPU traffic
    b_mul = n_mul; b_add = n_add;
    do_start(8'd0);
    check("s2_load_no_valid", 32'(res_valid), 32'd0);
    @(negedge clk);
    check("s2_valid", 32'(res_valid), 32'd1);
    check("s2_data", res_data, 32'd0);
    @(negedge clk);
    check("s2_valid_pulse", 32'(res_valid), 32'd0);
    check("s2_no_fpu", 32'(n_mul - b_mul + n_add - b_add), 32'd0);

    // Stall in WAIT_ELEM with a stray start that must be ignored
    b_mul = n_mul;
    do_start(8'd1);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("s3_ready_held", 32'(elem_ready), 32'd1);
      start = (i == 1);
      len   = 8'd0;
      @(negedge clk);
    end
    start = 1'b0;
    check("s3_no_mul", 32'(n_mul - b_mul), 32'd0);
    feed(32'h40400000, 32'h40400000);
    wait_res("s3_result", 32'h41100000);

    // Multiplier never answers: timeout on the 64th MUL_WAIT cycle
    mult_hang = 1'b1;
    b_res = n_res; b_err = n_err; kk = 0;
    do_start(8'd1);
    feed(32'h3F800000, 32'h3F800000);
    check("s4_mul_issue", 32'(mul_start), 32'd1);
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (k == 10) check("s4_operand_hold", fpu_a, 32'h3F800000);
      if (err_timeout) begin
        kk = k;
        break;
      end
    end
    check("s4_timeout_cycle", 32'(kk), 32'd64);
    @(negedge clk);
    check("s4_busy_fall", 32'(busy), 32'd0);
    check("s4_err_pulses", 32'(n_err - b_err), 32'd1);
    check("s4_no_res", 32'(n_res - b_res), 32'd0);
    check("s4_res_kept", res_data, 32'h41100000);
    mult_hang = 1'b0;
    repeat (4) @(negedge clk);

    // Reset during ADD_WAIT of element 2, then a fresh run
    b_add = n_add;
    do_start(8'd3);
    feed(32'h3F800000, 32'h3F800000);
    feed(32'h40000000, 32'h40000000);
    for (int t = 0; t < 50 && (n_add - b_add) < 2; t++) @(negedge clk);
    check("s5_add2_issued", 32'(n_add - b_add), 32'd2);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    check("s5_busy", 32'(busy), 32'd0);
    check("s5_outs", {27'd0, res_valid, err_timeout, elem_ready, mul_start, add_start}, 32'd0);
    check("s5_fpu_a", fpu_a, 32'd0);
    check("s5_fpu_b", fpu_b, 32'd0);
    check("s5_res_data", res_data, 32'd0);
    b_res = n_res;
    do_start(8'd1);
    feed(32'h40000000, 32'h40800000);
    wait_res("s5_result", 32'h41000000);
    check("s5_res_pulses", 32'(n_res - b_res), 32'd1);

`ifdef BIAS_INIT_EN
    bias = 32'h3F000000;
    do_start(8'd1);
    feed(32'h40000000, 32'h40800000);
    wait_res("s6_bias_result", 32'h41080000);
    do_start(8'd0);
    @(negedge clk);
    check("s6_bias_len0", res_data, 32'h3F000000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
